wd_router: RTL

WD_ROUTER -- requirements
Module: wd_router

---
 rtl/axi_wd_pkg.sv | 16 +
 rtl/wd_route_fifo.sv | 56 +++++
 rtl/wd_router.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/axi_wd_pkg.sv
// Shared types for the AXI write-data router: the {master,slave} route record
// and the one-hot encodings used for masters and slaves.
package axi_wd_pkg;

  typedef struct packed {
    logic [1:0] master;
    logic [2:0] slave;
  } route_t;

  localparam logic [1:0] M0 = 2'b01;
  localparam logic [1:0] M1 = 2'b10;
  localparam logic [2:0] S0 = 3'b001;
  localparam logic [2:0] S1 = 3'b010;
  localparam logic [2:0] SD = 3'b100;

endpackage

// File: rtl/wd_route_fifo.sv
// Queue of outstanding AW routes; head is the route the W channel currently follows.
// A push while full is taken only when a pop happens in the same cycle.
module wd_route_fifo
  import axi_wd_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  route_t push_route,
  input  logic   pop,
  output route_t head,
  output logic   empty,
  output logic   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;
  route_t        mem [DEPTH];

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: route storage is not reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_route;
  end

endmodule

// File: rtl/wd_router.sv
// AXI write-data router: steers W beats from the head-route master to its slave.
// Define WD_ROUTER_REG_EN to insert a one-entry W register slice (one cycle latency).
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module wd_router
  import axi_wd_pkg::*;
#(
  parameter int ROUTE_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      aw_push,
  input  logic [1:0]                aw_master,
  input  logic [2:0]                aw_slave,
  output logic                      aw_full,
  input  logic [`AXI_DATA_BITS-1:0] WDATA_M0,
  input  logic [`AXI_STRB_BITS-1:0] WSTRB_M0,
  input  logic                      WLAST_M0,
  input  logic                      WVALID_M0,
  output logic                      WREADY_M0,
  input  logic [`AXI_DATA_BITS-1:0] WDATA_M1,
  input  logic [`AXI_STRB_BITS-1:0] WSTRB_M1,
  input  logic                      WLAST_M1,
  input  logic                      WVALID_M1,
  output logic                      WREADY_M1,
  output logic [`AXI_DATA_BITS-1:0] WDATA_S0,
  output logic [`AXI_STRB_BITS-1:0] WSTRB_S0,
  output logic                      WLAST_S0,
  output logic                      WVALID_S0,
  input  logic                      WREADY_S0,
  output logic [`AXI_DATA_BITS-1:0] WDATA_S1,
  output logic [`AXI_STRB_BITS-1:0] WSTRB_S1,
  output logic                      WLAST_S1,
  output logic                      WVALID_S1,
  input  logic                      WREADY_S1,
  output logic [`AXI_DATA_BITS-1:0] WDATA_SDEFAULT,
  output logic [`AXI_STRB_BITS-1:0] WSTRB_SDEFAULT,
  output logic                      WLAST_SDEFAULT,
  output logic                      WVALID_SDEFAULT,
  input  logic                      WREADY_SDEFAULT
);

  localparam int DW = `AXI_DATA_BITS;
  localparam int SW = `AXI_STRB_BITS;

  route_t          new_route;
  route_t          head;
  logic            empty;
  logic            full;
  logic            route_vld;
  logic            sel_m0;
  logic            sel_m1;
  logic            pop;

  logic            m_valid;
  logic            m_last;
  logic [DW-1:0]   m_data;
  logic [SW-1:0]   m_strb;
  logic            m_ready;

  logic            sl_valid;
  logic            sl_last;
  logic [DW-1:0]   sl_data;
  logic [SW-1:0]   sl_strb;
  logic [2:0]      sl_dest;
  logic            sel_sready;

  assign new_route = '{master: aw_master, slave: aw_slave};

  wd_route_fifo #(.DEPTH(ROUTE_DEPTH)) u_route_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (aw_push),
    .push_route (new_route),
    .pop        (pop),
    .head       (head),
    .empty      (empty),
    .full       (full)
  );

  assign aw_full   = full;
  assign route_vld = !empty;
  // M0 wins if a malformed route ever carries both master bits.
  assign sel_m0    = route_vld && head.master[0];
  assign sel_m1    = route_vld && !head.master[0] && head.master[1];

  always_comb begin
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    m_strb  = '0;
    if (sel_m0) begin
      m_valid = WVALID_M0;
      m_last  = WLAST_M0;
      m_data  = WDATA_M0;
      m_strb  = WSTRB_M0;
    end else if (sel_m1) begin
      m_valid = WVALID_M1;
      m_last  = WLAST_M1;
      m_data  = WDATA_M1;
      m_strb  = WSTRB_M1;
    end
  end

  assign sel_sready = |(sl_dest & {WREADY_SDEFAULT, WREADY_S1, WREADY_S0});

`ifdef WD_ROUTER_REG_EN
  logic          s_vld;
  logic [2:0]    s_slave;
  logic [DW-1:0] s_data;
  logic [SW-1:0] s_strb;
  logic          s_last;
  logic          load;

  // The slice carries its own destination, so the route can pop as the last beat enters it.
  assign m_ready = route_vld && (!s_vld || sel_sready);
  assign load    = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_vld   <= 1'b0;
      s_slave <= '0;
      s_data  <= '0;
      s_strb  <= '0;
      s_last  <= 1'b0;
    end else if (load) begin
      s_vld   <= 1'b1;
      s_slave <= head.slave;
      s_data  <= m_data;
      s_strb  <= m_strb;
      s_last  <= m_last;
    end else if (s_vld && sel_sready) begin
      s_vld   <= 1'b0;
    end
  end

  assign sl_dest  = s_vld ? s_slave : 3'b000;
  assign sl_valid = s_vld;
  assign sl_data  = s_data;
  assign sl_strb  = s_strb;
  assign sl_last  = s_last;
`else
  assign m_ready  = sel_sready;
  assign sl_dest  = route_vld ? head.slave : 3'b000;
  assign sl_valid = m_valid;
  assign sl_data  = m_data;
  assign sl_strb  = m_strb;
  assign sl_last  = m_last;
`endif

  assign pop       = m_valid && m_ready && m_last;
  assign WREADY_M0 = sel_m0 && m_ready;
  assign WREADY_M1 = sel_m1 && m_ready;

  assign WVALID_S0       = sl_dest[0] && sl_valid;
  assign WDATA_S0        = sl_dest[0] ? sl_data : '0;
  assign WSTRB_S0        = sl_dest[0] ? sl_strb : '0;
  assign WLAST_S0        = sl_dest[0] && sl_last;
  assign WVALID_S1       = sl_dest[1] && sl_valid;
  assign WDATA_S1        = sl_dest[1] ? sl_data : '0;
  assign WSTRB_S1        = sl_dest[1] ? sl_strb : '0;
  assign WLAST_S1        = sl_dest[1] && sl_last;
  assign WVALID_SDEFAULT = sl_dest[2] && sl_valid;
  assign WDATA_SDEFAULT  = sl_dest[2] ? sl_data : '0;
  assign WSTRB_SDEFAULT  = sl_dest[2] ? sl_strb : '0;
  assign WLAST_SDEFAULT  = sl_dest[2] && sl_last;

endmodule
